video_frame_checker: RTL

VIDEO_FRAME_CHECKER -- requirements
Module: video_frame_checker

---
 rtl/video_frame_checker_pkg.sv | 9 +
 rtl/sync_edge_detect.sv | 26 ++
 rtl/video_frame_checker.sv | 89 ++++++++
 3 files changed

// File: rtl/video_frame_checker_pkg.sv
// video_frame_checker_pkg: widths and FSM state encodings shared by the frame checker
package video_frame_checker_pkg;
    localparam int SIG_W  = 16;
    localparam int COL_W  = 11;
    localparam int LINE_W = 10;
    localparam logic [1:0] ST_SEARCH  = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: registers a sync input once and flags its rising/falling edges
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_sync         : sync level input
//   o_rise, o_fall : single-cycle edge pulses, combinational from i_sync
module sync_edge_detect (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sync,
    output logic o_rise,
    output logic o_fall
);
    logic sync_q;
    logic armed;
    // armed masks the first sample after reset so a sync already high at release is not an edge
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= 1'b0;
            armed  <= 1'b0;
        end else begin
            sync_q <= i_sync;
            armed  <= 1'b1;
        end
    end
    assign o_rise = armed & i_sync & ~sync_q;
    assign o_fall = armed & ~i_sync & sync_q;
endmodule

// File: rtl/video_frame_checker.sv
// video_frame_checker: measures video frame timing and publishes a per-frame pixel checksum
//   i_clk, i_rst_n             : pixel clock, asynchronous active-low reset
//   i_hsync, i_vsync           : high during visible columns / visible rows
//   i_red/grn/blu_video        : pixel data aligned with the syncs
//   o_locked                   : frame timing matches all parameters
//   o_frame_valid              : one-clock publish pulse
//   o_signature, o_timing_err  : checksum and timing-error flag of the last complete frame
//   o_frame_count              : published frame count, wraps at 256
module video_frame_checker
    import video_frame_checker_pkg::*;
#(
    parameter int VIDEO_WIDTH = 3,
    parameter int H_VISIBLE   = 640,
    parameter int V_VISIBLE   = 480,
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_hsync,
    input  logic                   i_vsync,
    input  logic [VIDEO_WIDTH-1:0] i_red_video,
    input  logic [VIDEO_WIDTH-1:0] i_grn_video,
    input  logic [VIDEO_WIDTH-1:0] i_blu_video,
    output logic                   o_locked,
    output logic                   o_frame_valid,
    output logic [SIG_W-1:0]       o_signature,
    output logic                   o_timing_err,
    output logic [7:0]             o_frame_count
);
    logic              h_rise, h_fall, v_rise, v_fall;
    logic [COL_W-1:0]  col;
    logic [LINE_W-1:0] line, vis;
    logic [SIG_W-1:0]  pix, acc, pub_sig;
    logic [1:0]        state, state_n;
    logic              err, skip, pub_pend, pub_err;
    logic              line_bad, width_bad, frame_bad, frame_err;
    sync_edge_detect u_hs (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_sync(i_hsync), .o_rise(h_rise), .o_fall(h_fall));
    sync_edge_detect u_vs (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_sync(i_vsync), .o_rise(v_rise), .o_fall(v_fall));
    assign pix = (i_hsync && i_vsync) ? SIG_W'({i_red_video, i_grn_video, i_blu_video}) : '0;
    // counters hold the index of the cycle/line before the current edge, hence the +1
    always_comb begin
        line_bad  = h_rise && !skip && (int'(col) + 1 != H_TOTAL);
        width_bad = h_fall && (int'(col) + 1 != H_VISIBLE);
        frame_bad = (int'(line) + 1 != V_TOTAL) || (int'(vis) != V_VISIBLE);
        frame_err = err || line_bad || frame_bad;
        state_n   = !v_rise ? state : state == ST_SEARCH ? ST_MEASURE : frame_err ? ST_SEARCH : ST_LOCKED;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            col           <= '0;
            line          <= '0;
            vis           <= '0;
            acc           <= '0;
            err           <= 1'b0;
            skip          <= 1'b0;
            state         <= ST_SEARCH;
            pub_pend      <= 1'b0;
            pub_sig       <= '0;
            pub_err       <= 1'b0;
            o_locked      <= 1'b0;
            o_frame_valid <= 1'b0;
            o_signature   <= '0;
            o_timing_err  <= 1'b0;
            o_frame_count <= '0;
        end else begin
            col   <= h_rise ? '0 : (&col) ? col : col + COL_W'(1);
            line  <= v_rise ? '0 : (!h_rise || (&line)) ? line : line + LINE_W'(1);
            // visible line count is captured when vsync drops, from the line it drops on
            vis   <= v_rise ? '0 : v_fall ? ((&line) ? line : line + LINE_W'(1)) : vis;
            acc   <= v_rise ? pix : acc + pix;
            err   <= v_rise ? 1'b0 : err | line_bad | width_bad;
            skip  <= v_rise ? (state == ST_SEARCH) : skip && !h_rise;
            state <= state_n;
            pub_pend <= v_rise && state != ST_SEARCH;
            if (v_rise) begin
                pub_sig <= acc;
                pub_err <= frame_err;
            end
            o_locked      <= state == ST_LOCKED;
            o_frame_valid <= pub_pend;
            if (pub_pend) begin
                o_signature   <= pub_sig;
                o_timing_err  <= pub_err;
                o_frame_count <= o_frame_count + 8'd1;
            end
        end
    end
endmodule
